// File: rtl/feistel_pkg.sv
// Shared definitions for the nibble-Feistel encrypt/decrypt datapaths.
package feistel_pkg;

  localparam int NIB_W      = 4;
  localparam int LAT_SERIAL = 5;
  localparam int LAT_PAR    = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    ADD,
    EMIT
  } state_t;

  function automatic logic [7:0] expand(input logic [NIB_W-1:0] l);
    return {l[3], l[0], l[1], l[2], l[1], l[3], l[2], l[0]};
  endfunction

endpackage

// File: rtl/feistel_decrypt_unit_adder.sv
// Nibble adder for the round function: one bit per step, or whole nibble.
module serial_nibble_adder
  import feistel_pkg::*;
#(
  parameter bit BIT_SERIAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic             done,
  output logic [NIB_W-1:0] sum
);

  logic [1:0]       cnt;
  logic             carry_r;
  logic [NIB_W-1:0] sum_r;
  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             bit_c;

  assign bit_a = a[cnt];
  assign bit_b = b[cnt];
  assign bit_s = bit_a ^ bit_b ^ carry_r;
  assign bit_c = (bit_a & bit_b) | (bit_a & carry_r) | (bit_b & carry_r);

  // sum is the value sum_r takes on this step, so the final one can be used directly
  always_comb begin
    sum = sum_r;
    if (BIT_SERIAL) begin
      sum[cnt] = bit_s;
    end else begin
      sum = a + b + {3'b000, carry_r};
    end
    done = step && (BIT_SERIAL ? (cnt == 2'd3) : 1'b1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
    end else if (start) begin
      cnt     <= '0;
      carry_r <= cin;
      sum_r   <= '0;
    end else if (step) begin
      cnt     <= cnt + 2'd1;
      carry_r <= bit_c;
      sum_r   <= sum;
    end
  end

endmodule

// File: rtl/feistel_decrypt_unit.sv
// Iterative nibble-Feistel decryptor: recomputes F from the low nibble
// and unmasks the high nibble of the ciphertext.
module feistel_decrypt_unit
  import feistel_pkg::*;
#(
  parameter bit BIT_SERIAL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] enc_in,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dec_out,
  output logic [3:0] f_out,
  output logic       busy
);

  state_t     state;
  logic [7:0] enc_r;
  logic [7:0] key_r;
  logic [7:0] x_r;
  logic       add_done;
  logic [3:0] add_sum;

  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);

  serial_nibble_adder #(
    .BIT_SERIAL(BIT_SERIAL)
  ) u_adder (
    .clock(clock),
    .reset(reset),
    .start(state == EXPAND),
    .step (state == ADD),
    .a    (x_r[7:4]),
    .b    (x_r[3:0]),
    .cin  (key_r[0]),
    .done (add_done),
    .sum  (add_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      enc_r     <= '0;
      key_r     <= '0;
      x_r       <= '0;
      dec_out   <= '0;
      f_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            enc_r <= enc_in;
            key_r <= key_in;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          x_r   <= expand(enc_r[3:0]) ^ key_r;
          state <= ADD;
        end
        ADD: begin
          if (add_done) begin
            dec_out   <= {enc_r[7:4] ^ add_sum, enc_r[3:0]};
            f_out     <= add_sum;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
